ex_mem_branch_stage: RTL

- EX→MEM pipeline register that consumes the 1-bit zero flag from the EX-stage 32-bit zero detector, alongside the ALU result.
- Resolves conditional and unconditional branches, registers the EX payload for MEM, and drives the redirect/flush request to the fetch stage.
- Squashes the SHADOW wrong-path instructions that follow a taken branch, using a small state machine.

---
 rtl/ex_mem_branch_stage.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ex_mem_branch_stage.sv
// rtl/ex_mem_branch_stage.sv - EX/MEM pipeline register with branch resolution and shadow squash
module ex_mem_branch_stage #(
    parameter int DW     = 32,
    parameter int RW     = 5,
    parameter int SHADOW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ex_valid,
    input  logic [DW-1:0] ex_alu_result,
    input  logic          ex_zero,
    input  logic [2:0]    ex_br_op,
    input  logic [DW-1:0] ex_br_target,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_reg_wr,
    input  logic          ex_mem_rd,
    input  logic          ex_mem_wr,
    input  logic          mem_stall,
    input  logic          ext_flush,
    output logic          mem_valid,
    output logic [DW-1:0] mem_alu_result,
    output logic          mem_zero,
    output logic [RW-1:0] mem_rd,
    output logic          mem_reg_wr,
    output logic          mem_mem_rd,
    output logic          mem_mem_wr,
    output logic          redirect,
    output logic [DW-1:0] redirect_pc
);

    // Counter is 2 bits wide: SHADOW is limited to 1..3.
    localparam int CW = 2;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLTZ = 3'b011;
    localparam logic [2:0] BR_BLEZ = 3'b100;
    localparam logic [2:0] BR_BGTZ = 3'b101;
    localparam logic [2:0] BR_BGEZ = 3'b110;
    localparam logic [2:0] BR_JUMP = 3'b111;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          mem_valid_q, mem_valid_d;
    logic [DW-1:0] mem_alu_result_q, mem_alu_result_d;
    logic          mem_zero_q, mem_zero_d;
    logic [RW-1:0] mem_rd_q, mem_rd_d;
    logic          mem_reg_wr_q, mem_reg_wr_d;
    logic          mem_mem_rd_q, mem_mem_rd_d;
    logic          mem_mem_wr_q, mem_mem_wr_d;
    logic          redirect_q, redirect_d;
    logic [DW-1:0] redirect_pc_q, redirect_pc_d;

    logic sign;
    logic cond;
    logic squashing;
    logic live;
    logic taken;

    // Branch condition from the sign bit and the upstream zero flag.
    always_comb begin
        sign = ex_alu_result[DW-1];
        cond = 1'b0;
        case (ex_br_op)
            BR_BEQ:  cond = ex_zero;
            BR_BNE:  cond = !ex_zero;
            BR_BLTZ: cond = sign;
            BR_BLEZ: cond = sign | ex_zero;
            BR_BGTZ: cond = !sign & !ex_zero;
            BR_BGEZ: cond = !sign;
            BR_JUMP: cond = 1'b1;
            BR_NONE: cond = 1'b0;
            default: cond = 1'b0;
        endcase
        squashing = (state_q == ST_SQUASH);
        live      = ex_valid && !squashing;
        taken     = live && cond;
    end

    // Next-state: flush beats stall, stall freezes everything, else load and track the shadow.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        mem_valid_d      = mem_valid_q;
        mem_alu_result_d = mem_alu_result_q;
        mem_zero_d       = mem_zero_q;
        mem_rd_d         = mem_rd_q;
        mem_reg_wr_d     = mem_reg_wr_q;
        mem_mem_rd_d     = mem_mem_rd_q;
        mem_mem_wr_d     = mem_mem_wr_q;
        redirect_d       = 1'b0;
        redirect_pc_d    = redirect_pc_q;

        if (!mem_stall) begin
            mem_alu_result_d = ex_alu_result;
            mem_zero_d       = ex_zero;
            mem_rd_d         = ex_rd;
        end

        if (ext_flush) begin
            mem_valid_d  = 1'b0;
            mem_reg_wr_d = 1'b0;
            mem_mem_rd_d = 1'b0;
            mem_mem_wr_d = 1'b0;
            state_d      = ST_RUN;
            cnt_d        = '0;
        end else if (!mem_stall) begin
            mem_valid_d  = live;
            mem_reg_wr_d = live && ex_reg_wr;
            mem_mem_rd_d = live && ex_mem_rd;
            mem_mem_wr_d = live && ex_mem_wr;
            if (taken) begin
                redirect_d    = 1'b1;
                redirect_pc_d = ex_br_target;
                state_d       = ST_SQUASH;
                cnt_d         = CW'(SHADOW);
            end else if (squashing && ex_valid) begin
                // Only real instructions consume a shadow slot; bubbles do not.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_RUN;
                end
            end
        end
    end

    // State and pipeline registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_RUN;
            cnt_q            <= '0;
            mem_valid_q      <= 1'b0;
            mem_alu_result_q <= '0;
            mem_zero_q       <= 1'b0;
            mem_rd_q         <= '0;
            mem_reg_wr_q     <= 1'b0;
            mem_mem_rd_q     <= 1'b0;
            mem_mem_wr_q     <= 1'b0;
            redirect_q       <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            mem_valid_q      <= mem_valid_d;
            mem_alu_result_q <= mem_alu_result_d;
            mem_zero_q       <= mem_zero_d;
            mem_rd_q         <= mem_rd_d;
            mem_reg_wr_q     <= mem_reg_wr_d;
            mem_mem_rd_q     <= mem_mem_rd_d;
            mem_mem_wr_q     <= mem_mem_wr_d;
            redirect_q       <= redirect_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign mem_valid      = mem_valid_q;
    assign mem_alu_result = mem_alu_result_q;
    assign mem_zero       = mem_zero_q;
    assign mem_rd         = mem_rd_q;
    assign mem_reg_wr     = mem_reg_wr_q;
    assign mem_mem_rd     = mem_mem_rd_q;
    assign mem_mem_wr     = mem_mem_wr_q;
    assign redirect       = redirect_q;
    assign redirect_pc    = redirect_pc_q;

endmodule
